// File: rtl/wb_imem_loader.sv
`default_nettype none
// wb_imem_loader: Wishbone slave that buffers program words into a small FIFO feeding
// instruction memory, and holds the RISC-V core in reset until RUN is set and the FIFO drains.
module wb_imem_loader #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          IMEM_AW    = 8,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic               imem_we_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  output logic [31:0]        imem_wdata_o,
  input  logic               imem_ready_i,
  output logic               core_rst_n_o
);

  localparam int            PW       = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [1:0]    REG_CTRL   = 2'd0;
  localparam logic [1:0]    REG_ADDR   = 2'd1;
  localparam logic [1:0]    REG_DATA   = 2'd2;
  localparam logic [1:0]    REG_STATUS = 2'd3;

  logic [IMEM_AW-1:0] addr_q;
  logic               run_q;
  logic               err_q;
  logic [15:0]        words_q;
  logic               ack_q;
  logic [31:0]        dat_q;
  logic               core_rst_q;

  logic [IMEM_AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [31:0]        fifo_data [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [PW:0]        count;

  logic        fifo_empty;
  logic        fifo_full;
  logic        hit;
  logic        req;
  logic [1:0]  reg_sel;
  logic        data_wr;
  logic        stall;
  logic        push;
  logic        pop;
  logic        clr_cnt;
  logic [31:0] rdata;
  logic        unused_ok;

  assign unused_ok  = ^{wbs_sel_i, wbs_adr_i[1:0]};

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign hit        = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign req        = wbs_stb_i & wbs_cyc_i & hit & ~ack_q;
  assign reg_sel    = wbs_adr_i[3:2];
  assign data_wr    = req & wbs_we_i & (reg_sel == REG_DATA);
  // A full FIFO is judged on the registered count, so a pop frees space one edge before the push.
  assign stall      = data_wr & ~run_q & fifo_full;
  assign push       = data_wr & ~run_q & ~fifo_full;
  assign pop        = ~fifo_empty & imem_ready_i;
  assign clr_cnt    = req & wbs_we_i & (reg_sel == REG_CTRL) & wbs_dat_i[1];

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL:   rdata[0] = run_q;
      REG_ADDR:   rdata[IMEM_AW-1:0] = addr_q;
      REG_STATUS: rdata = {words_q, 12'b0, err_q, run_q, fifo_full, fifo_empty};
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      run_q      <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      core_rst_q <= 1'b0;
    end else begin
      ack_q      <= req & ~stall;
      dat_q      <= (req & ~wbs_we_i) ? rdata : '0;
      core_rst_q <= run_q & fifo_empty;
      if (req && wbs_we_i) begin
        case (reg_sel)
          REG_CTRL: begin
            run_q <= wbs_dat_i[0];
            if (wbs_dat_i[2]) err_q <= 1'b0;
          end
          REG_ADDR: addr_q <= wbs_dat_i[IMEM_AW-1:0];
          REG_DATA: begin
            if (run_q)     err_q  <= 1'b1;
            else if (push) addr_q <= addr_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_q <= '0;
    end else if (clr_cnt) begin
      words_q <= '0;
    end else if (pop && words_q != 16'hFFFF) begin
      words_q <= words_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= addr_q;
        fifo_data[wr_ptr] <= wbs_dat_i;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;
  assign imem_we_o    = ~fifo_empty;
  assign imem_addr_o  = fifo_addr[rd_ptr];
  assign imem_wdata_o = fifo_data[rd_ptr];
  assign core_rst_n_o = core_rst_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_imem_loader.sv
`default_nettype none
// tb_wb_imem_loader: register table, hand-written corner sequences and a randomized
// run against a transaction-level model of the loader.
module tb_wb_imem_loader;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = '0, dat_i = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_ready;
  logic        core_rst_n;

  logic rand_ready = 1'b0, ready_force = 1'b1, rnd_bit = 1'b0;
  assign imem_ready = rand_ready ? rnd_bit : ready_force;

  wb_imem_loader #(.BASE_ADDR(BASE), .IMEM_AW(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .imem_we_o(imem_we), .imem_addr_o(imem_addr), .imem_wdata_o(imem_wdata),
    .imem_ready_i(imem_ready), .core_rst_n_o(core_rst_n)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk); #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // Memory writes actually performed, captured mid-cycle before the popping edge.
  logic [39:0] obs_q[$];
  logic [39:0] exp_q[$];
  always @(negedge clk) if (rst_n && imem_we && imem_ready) obs_q.push_back({imem_addr, imem_wdata});

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] m_addr = '0;
  logic       m_run = 1'b0, m_err = 1'b0;
  int         m_words = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  off;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wb_cycle(input logic [31:0] a, input logic w, input logic [31:0] d, output logic [31:0] rd);
    int n = 0;
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d;
    rd = '0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 200);
    if (!ack) begin
      checks++; errors++;
      $display("FAIL ack_timeout addr %h: no ack after %0d cycles, ack required", a, n);
    end else begin
      rd = dat_o;
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  // Let the FIFO empty, then compare performed writes against the model's expected list.
  task automatic drain(input string name);
    int  n = 0;
    logic saved = rand_ready;
    rand_ready = 1'b0; ready_force = 1'b1;
    while (imem_we && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (imem_we) begin
      checks++; errors++;
      $display("FAIL %s_drain_timeout: imem_we still 1, 0 required", name);
    end
    @(negedge clk);
    check({name, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_w%0d", name, i), 64'(obs_q[i]), 64'(exp_q[i]));
    m_words += exp_q.size();
    if (m_words > 65535) m_words = 65535;
    obs_q.delete();
    exp_q.delete();
    rand_ready = saved;
  endtask

  task automatic do_write(input logic [1:0] off, input logic [31:0] d);
    logic [31:0] rd;
    if (off == 2'd0 && d[1]) drain("pre_clr");
    wb_cycle(BASE | {28'b0, off, 2'b00}, 1'b1, d, rd);
    case (off)
      2'd0: begin
        m_run = d[0];
        if (d[1]) m_words = 0;
        if (d[2]) m_err = 1'b0;
      end
      2'd1: m_addr = d[7:0];
      2'd2: begin
        if (m_run) m_err = 1'b1;
        else begin
          exp_q.push_back({m_addr, d});
          m_addr = m_addr + 8'd1;
        end
      end
      default: ;
    endcase
  endtask

  task automatic do_read(input logic [1:0] off, input string name);
    logic [31:0] rd, e;
    if (off == 2'd3) drain({name, "_pre"});
    wb_cycle(BASE | {28'b0, off, 2'b00}, 1'b0, '0, rd);
    case (off)
      2'd0:    e = {31'b0, m_run};
      2'd1:    e = {24'b0, m_addr};
      2'd3:    e = {16'(m_words), 12'b0, m_err, m_run, 1'b0, 1'b1};
      default: e = '0;
    endcase
    check(name, 64'(rd), 64'(e));
  endtask

  initial begin
    logic [31:0] rd;
    logic        seen;
    int          n;

    vecs[0]  = '{1'b0, 2'd3, 32'h0,         32'h0000_0001};
    vecs[1]  = '{1'b0, 2'd0, 32'h0,         32'h0000_0000};
    vecs[2]  = '{1'b1, 2'd1, 32'h0000_01A5, 32'h0};
    vecs[3]  = '{1'b0, 2'd1, 32'h0,         32'h0000_00A5};
    vecs[4]  = '{1'b1, 2'd0, 32'h0000_0006, 32'h0};
    vecs[5]  = '{1'b0, 2'd0, 32'h0,         32'h0000_0000};
    vecs[6]  = '{1'b0, 2'd2, 32'h0,         32'h0000_0000};
    vecs[7]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0};
    vecs[8]  = '{1'b0, 2'd3, 32'h0,         32'h0000_0001};
    vecs[9]  = '{1'b1, 2'd1, 32'h0000_0000, 32'h0};
    vecs[10] = '{1'b0, 2'd1, 32'h0,         32'h0000_0000};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_dat", 64'(dat_o), 64'd0);
    check("rst_imem_we", 64'(imem_we), 64'd0);
    check("rst_imem_addr", 64'(imem_addr), 64'd0);
    check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    check("rst_core", 64'(core_rst_n), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].wr) do_write(vecs[i].off, vecs[i].d);
      else begin
        wb_cycle(BASE | {28'b0, vecs[i].off, 2'b00}, 1'b0, '0, rd);
        check($sformatf("vec%0d", i), 64'(rd), 64'(vecs[i].exp));
      end
    end

    // Addresses outside the 16-byte window never get an ack
    seen = 1'b0;
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE + 32'h10;
    repeat (6) begin @(posedge clk); #1; seen = seen | ack; end
    adr = 32'h2000_0000;
    repeat (6) begin @(posedge clk); #1; seen = seen | ack; end
    stb = 1'b0; cyc = 1'b0;
    check("nohit_ack", 64'(seen), 64'd0);

    // Sequential load
    ready_force = 1'b1;
    do_write(2'd1, 32'h10);
    do_write(2'd2, 32'hAAAA_0001);
    do_write(2'd2, 32'hAAAA_0002);
    do_write(2'd2, 32'hAAAA_0003);
    drain("seq");
    do_read(2'd3, "seq_status");
    do_read(2'd1, "seq_addr");

    // Backpressure: fifth write stalls until a pop frees space
    ready_force = 1'b0;
    for (int i = 0; i < 4; i++) do_write(2'd2, 32'hB000_0000 + 32'(i));
    wb_cycle(BASE | 32'hC, 1'b0, '0, rd);
    check("bp_status_full", 64'(rd), 64'h0003_0002);
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = BASE | 32'h8; dat_i = 32'hB000_0004;
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; seen = seen | ack; end
    check("bp_stall_noack", 64'(seen), 64'd0);
    ready_force = 1'b1;
    @(posedge clk); #1;
    check("bp_ack_not_at_pop", 64'(ack), 64'd0);
    @(posedge clk); #1;
    check("bp_ack_after_pop", 64'(ack), 64'd1);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    exp_q.push_back({m_addr, 32'hB000_0004});
    m_addr = m_addr + 8'd1;
    drain("bp");

    // Run gating: core leaves reset only once the FIFO has drained
    ready_force = 1'b0;
    do_write(2'd2, 32'hC000_0001);
    do_write(2'd2, 32'hC000_0002);
    do_write(2'd0, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    check("gate_hold", 64'(core_rst_n), 64'd0);
    ready_force = 1'b1;
    n = 0;
    while (imem_we && n < 20) begin @(posedge clk); #1; n++; end
    check("gate_empty_edge", 64'({imem_we, core_rst_n}), 64'd0);
    @(posedge clk); #1;
    check("gate_release", 64'(core_rst_n), 64'd1);
    drain("gate");
    do_write(2'd0, 32'h0);
    @(posedge clk); #1;
    check("gate_rerst", 64'(core_rst_n), 64'd0);

    // Address wrap and error flag
    do_write(2'd1, 32'hFF);
    do_write(2'd2, 32'hBEEF_00FF);
    drain("wrap");
    do_read(2'd1, "wrap_addr");
    do_write(2'd0, 32'h1);
    do_write(2'd2, 32'h1234_5678);
    repeat (5) @(posedge clk);
    drain("err_nowrite");
    do_read(2'd3, "err_status");
    do_write(2'd0, 32'h5);
    do_read(2'd3, "clrerr_status");
    do_write(2'd0, 32'h0);

    // Randomized traffic against the model
    rand_ready = 1'b1;
    for (int k = 0; k < 150; k++) begin
      int r = int'($urandom_range(0, 9));
      if (r <= 4)      do_write(2'd2, $urandom);
      else if (r == 5) do_write(2'd1, $urandom);
      else if (r == 6) do_write(2'd0, {$urandom_range(0, 3), 1'b0, ($urandom_range(0, 3) == 0)});
      else if (r == 7) do_read(2'd1, "rnd_addr");
      else if (r == 8) do_read(2'd0, "rnd_ctrl");
      else             do_read(2'd3, "rnd_status");
    end
    drain("rnd_end");
    repeat (2) @(posedge clk);
    #1;
    check("rnd_core_rst", 64'(core_rst_n), 64'(m_run));
    rand_ready = 1'b0;

    // Asynchronous reset mid-operation
    do_write(2'd0, 32'h0);
    ready_force = 1'b0;
    for (int i = 0; i < 3; i++) do_write(2'd2, 32'hD000_0000 + 32'(i));
    do_write(2'd0, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = BASE | 32'hC;
    rst_n = 1'b0;
    #1;
    check("arst_imem_we", 64'(imem_we), 64'd0);
    check("arst_core", 64'(core_rst_n), 64'd0);
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; seen = seen | ack; end
    check("arst_noack", 64'(seen), 64'd0);
    stb = 1'b0; cyc = 1'b0;
    obs_q.delete();
    exp_q.delete();
    m_run = 1'b0; m_addr = '0; m_err = 1'b0; m_words = 0;
    ready_force = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_read(2'd3, "arst_status");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
